ltl_nfa_monitor: RTL and testbench

- Parametrised, run-time-programmable successor to the per-property hard-wired LTL monitor automata.
- One homogeneous NFA of NUM_STE state-transition elements consumes one SYM_W-bit trace symbol per valid cycle.
- Per-STE symbol sets, predecessor edges, start types and report enables are loaded through a config port, so one instance can serve any property cluster.
- Sits beside the core trace tap. Report vector, violation counters and first-report position are exported to the monitor aggregator.

---
 rtl/ltl_mon_pkg.sv | 33 +++
 rtl/ltl_ste_cell.sv | 81 ++++++++
 rtl/ltl_nfa_monitor.sv | 135 +++++++++++++
 tb/tb_ltl_nfa_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ltl_mon_pkg
// Purpose  : Shared types and constants for the programmable LTL NFA monitor.
//            Defines the config opcode encoding, the STE start types and the
//            bit positions of the ATTR config word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ltl_mon_pkg;

  typedef enum logic [1:0] {
    CFG_MATCH = 2'd0,
    CFG_EDGE  = 2'd1,
    CFG_ATTR  = 2'd2,
    CFG_CLEAR = 2'd3
  } cfg_op_e;

  // ST_RSVD behaves exactly like ST_NONE: only SOD and ALL enable an STE.
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SOD  = 2'd1,
    ST_ALL  = 2'd2,
    ST_RSVD = 2'd3
  } start_type_e;

  // ATTR write data layout
  localparam int ATTR_START_LSB  = 0;
  localparam int ATTR_START_MSB  = 1;
  localparam int ATTR_REPORT_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/ltl_ste_cell.sv
`default_nettype none
// ============================================================================
// Module   : ltl_ste_cell
// Purpose  : One state-transition element of the homogeneous NFA. Holds the
//            per-symbol match table, the predecessor row, the start type and
//            report enable, plus the active bit and its next-state logic.
// Ports    : clk, reset (sync, active-low)
//            consume     - a symbol is consumed this cycle
//            clear       - drop the active bit (restart / CLEAR)
//            sod_armed   - start-of-data window is open
//            active_vec  - active bits of all STEs (predecessor source)
//            symbols     - current trace symbol
//            wr_match/wr_edge/wr_attr, cfg_addr, cfg_wdata - config writes
//            active      - registered active bit
//            active_next - value active takes if this symbol is consumed
//            report_en   - report enable of this STE
// Revision : 1.0 - initial release
// ============================================================================
module ltl_ste_cell
  import ltl_mon_pkg::*;
#(
  parameter int NUM_STE = 9,
  parameter int SYM_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               consume,
  input  logic               clear,
  input  logic               sod_armed,
  input  logic [NUM_STE-1:0] active_vec,
  input  logic [SYM_W-1:0]   symbols,
  input  logic               wr_match,
  input  logic               wr_edge,
  input  logic               wr_attr,
  input  logic [SYM_W-1:0]   cfg_addr,
  input  logic [NUM_STE-1:0] cfg_wdata,
  output logic               active,
  output logic               active_next,
  output logic               report_en
);

  localparam int c_depth = 2 ** SYM_W;

  logic [c_depth-1:0] r_match;
  logic [NUM_STE-1:0] r_pred;
  start_type_e        r_start;
  logic               r_rpt;
  logic               r_active;
  logic               w_en;

  always_comb begin
    w_en = (|(active_vec & r_pred))
         | (r_start == ST_ALL)
         | ((r_start == ST_SOD) & sod_armed);
    active_next = w_en & r_match[symbols];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_match  <= '0;
      r_pred   <= '0;
      r_start  <= ST_NONE;
      r_rpt    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      if (wr_match) r_match[cfg_addr] <= cfg_wdata[0];
      if (wr_edge)  r_pred <= cfg_wdata;
      if (wr_attr) begin
        r_start <= start_type_e'(cfg_wdata[ATTR_START_MSB:ATTR_START_LSB]);
        r_rpt   <= cfg_wdata[ATTR_REPORT_BIT];
      end
      if (clear)        r_active <= 1'b0;
      else if (consume) r_active <= active_next;
    end
  end

  assign active    = r_active;
  assign report_en = r_rpt;

endmodule
`default_nettype wire

// File: rtl/ltl_nfa_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ltl_nfa_monitor
// Purpose  : Run-time programmable NFA monitor for LTL property clusters.
//            Consumes one trace symbol per valid cycle, reports active STEs
//            with report enabled, counts symbols and report cycles and
//            captures the position of the first report.
// Ports    : clk, reset (sync, active-low)
//            run, sym_valid, symbols, restart - trace input / control
//            cfg_we, cfg_op, cfg_ste, cfg_addr, cfg_wdata, cfg_err - config
//            report_vec, report_any, report_count, sym_count,
//            first_report_valid, first_report_idx - results
// Revision : 1.0 - initial release
// ============================================================================
module ltl_nfa_monitor
  import ltl_mon_pkg::*;
#(
  parameter int NUM_STE = 9,
  parameter int SYM_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       sym_valid,
  input  logic [SYM_W-1:0]           symbols,
  input  logic                       restart,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_op,
  input  logic [$clog2(NUM_STE)-1:0] cfg_ste,
  input  logic [SYM_W-1:0]           cfg_addr,
  input  logic [NUM_STE-1:0]         cfg_wdata,
  output logic                       cfg_err,
  output logic [NUM_STE-1:0]         report_vec,
  output logic                       report_any,
  output logic [CNT_W-1:0]           report_count,
  output logic [CNT_W-1:0]           sym_count,
  output logic                       first_report_valid,
  output logic [CNT_W-1:0]           first_report_idx
);

  cfg_op_e            w_op;
  logic               w_consume;
  logic               w_ste_ok;
  logic               w_cfg_acc;
  logic               w_clear;
  logic               w_next_rpt;
  logic [NUM_STE-1:0] w_sel;
  logic [NUM_STE-1:0] w_active;
  logic [NUM_STE-1:0] w_active_next;
  logic [NUM_STE-1:0] w_rpt_mask;

  logic               r_sod_armed;
  logic               r_cfg_err;
  logic               r_first_valid;
  logic [CNT_W-1:0]   r_sym_count;
  logic [CNT_W-1:0]   r_report_count;
  logic [CNT_W-1:0]   r_first_idx;

  always_comb begin
    w_op      = cfg_op_e'(cfg_op);
    w_consume = run & sym_valid & ~restart;
    // CLEAR does not address an STE, so its index is never range-checked.
    w_ste_ok  = (w_op == CFG_CLEAR) || (int'(cfg_ste) < NUM_STE);
    w_cfg_acc = cfg_we & ~run & w_ste_ok;
    w_clear   = restart | (w_cfg_acc & (w_op == CFG_CLEAR));
    // Report decision uses the post-consume active vector.
    w_next_rpt = |(w_active_next & w_rpt_mask);
    w_sel = '0;
    if (w_cfg_acc && (w_op != CFG_CLEAR)) w_sel[cfg_ste] = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_STE; gi++) begin : g_ste
    ltl_ste_cell #(
      .NUM_STE (NUM_STE),
      .SYM_W   (SYM_W)
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .consume     (w_consume),
      .clear       (w_clear),
      .sod_armed   (r_sod_armed),
      .active_vec  (w_active),
      .symbols     (symbols),
      .wr_match    (w_sel[gi] & (w_op == CFG_MATCH)),
      .wr_edge     (w_sel[gi] & (w_op == CFG_EDGE)),
      .wr_attr     (w_sel[gi] & (w_op == CFG_ATTR)),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .active      (w_active[gi]),
      .active_next (w_active_next[gi]),
      .report_en   (w_rpt_mask[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sod_armed    <= 1'b1;
      r_cfg_err      <= 1'b0;
      r_first_valid  <= 1'b0;
      r_sym_count    <= '0;
      r_report_count <= '0;
      r_first_idx    <= '0;
    end else begin
      r_cfg_err <= cfg_we & (run | ~w_ste_ok);
      if (w_clear) begin
        r_sod_armed    <= 1'b1;
        r_first_valid  <= 1'b0;
        r_sym_count    <= '0;
        r_report_count <= '0;
        r_first_idx    <= '0;
      end else if (w_consume) begin
        r_sod_armed <= 1'b0;
        if (r_sym_count != '1) r_sym_count <= r_sym_count + CNT_W'(1);
        if (w_next_rpt) begin
          if (r_report_count != '1) r_report_count <= r_report_count + CNT_W'(1);
          if (!r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_idx   <= r_sym_count;
          end
        end
      end
    end
  end

  assign cfg_err            = r_cfg_err;
  assign report_vec         = w_active & w_rpt_mask;
  assign report_any         = |report_vec;
  assign report_count       = r_report_count;
  assign sym_count          = r_sym_count;
  assign first_report_valid = r_first_valid;
  assign first_report_idx   = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_ltl_nfa_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltl_nfa_monitor
// Purpose  : Self-checking bench for ltl_nfa_monitor (NUM_STE=9, SYM_W=8,
//            CNT_W=4 so counter saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltl_nfa_monitor;

  localparam int NUM_STE = 9;
  localparam int SYM_W   = 8;
  localparam int CNT_W   = 4;

  localparam logic [1:0] OP_MATCH = 2'd0;
  localparam logic [1:0] OP_EDGE  = 2'd1;
  localparam logic [1:0] OP_ATTR  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic               clk;
  logic               reset;
  logic               run;
  logic               sym_valid;
  logic [SYM_W-1:0]   symbols;
  logic               restart;
  logic               cfg_we;
  logic [1:0]         cfg_op;
  logic [3:0]         cfg_ste;
  logic [SYM_W-1:0]   cfg_addr;
  logic [NUM_STE-1:0] cfg_wdata;
  logic               cfg_err;
  logic [NUM_STE-1:0] report_vec;
  logic               report_any;
  logic [CNT_W-1:0]   report_count;
  logic [CNT_W-1:0]   sym_count;
  logic               first_report_valid;
  logic [CNT_W-1:0]   first_report_idx;

  ltl_nfa_monitor #(
    .NUM_STE (NUM_STE),
    .SYM_W   (SYM_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .run                (run),
    .sym_valid          (sym_valid),
    .symbols            (symbols),
    .restart            (restart),
    .cfg_we             (cfg_we),
    .cfg_op             (cfg_op),
    .cfg_ste            (cfg_ste),
    .cfg_addr           (cfg_addr),
    .cfg_wdata          (cfg_wdata),
    .cfg_err            (cfg_err),
    .report_vec         (report_vec),
    .report_any         (report_any),
    .report_count       (report_count),
    .sym_count          (sym_count),
    .first_report_valid (first_report_valid),
    .first_report_idx   (first_report_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               run;
    logic               valid;
    logic               rs;
    logic [SYM_W-1:0]   sym;
    logic [NUM_STE-1:0] rv;
    logic [CNT_W-1:0]   sc;
    logic [CNT_W-1:0]   rc;
    logic               fv;
    logic [CNT_W-1:0]   fi;
  } vec_t;

  vec_t ta[17];
  vec_t tb[6];
  vec_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic r, logic v, logic rs, logic [7:0] s,
                              logic [8:0] rv, logic [3:0] sc, logic [3:0] rc,
                              logic fv, logic [3:0] fi);
    vec_t x;
    x.run = r; x.valid = v; x.rs = rs; x.sym = s;
    x.rv = rv; x.sc = sc; x.rc = rc; x.fv = fv; x.fi = fi;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".report_vec"},  32'(report_vec),         32'(e.rv));
    chk({tag, ".report_any"},  32'(report_any),         32'(|e.rv));
    chk({tag, ".sym_count"},   32'(sym_count),          32'(e.sc));
    chk({tag, ".report_cnt"},  32'(report_count),       32'(e.rc));
    chk({tag, ".first_valid"}, 32'(first_report_valid), 32'(e.fv));
    chk({tag, ".first_idx"},   32'(first_report_idx),   32'(e.fi));
  endtask

  task automatic check_zero(input string tag);
    check_outs(tag, mk(0, 0, 0, 8'h00, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  // Drive one vector, queue its expectation, pop and compare after the edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    run       = v.run;
    sym_valid = v.valid;
    symbols   = v.sym;
    restart   = v.rs;
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_outs(tag, e);
  endtask

  task automatic idle_inputs();
    run = 1'b0; sym_valid = 1'b0; restart = 1'b0; symbols = '0;
  endtask

  task automatic cfg_wr(input logic [1:0] op, input int ste, input int addr, input int wd);
    cfg_we    = 1'b1;
    cfg_op    = op;
    cfg_ste   = ste[3:0];
    cfg_addr  = addr[7:0];
    cfg_wdata = wd[8:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; sym_valid = 1'b0; symbols = '0; restart = 1'b0;
    cfg_we = 1'b0; cfg_op = '0; cfg_ste = '0; cfg_addr = '0; cfg_wdata = '0;

    // SOD chain: STE0 {0..3} self-loop, STE1 follows STE0 on 0x04 and reports
    ta[0]  = mk(1, 1, 0, 8'h01, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0);
    ta[1]  = mk(1, 1, 0, 8'h02, 9'h000, 4'd2, 4'd0, 1'b0, 4'd0);
    ta[2]  = mk(1, 1, 0, 8'h04, 9'h002, 4'd3, 4'd1, 1'b1, 4'd2);
    ta[3]  = mk(1, 0, 0, 8'h00, 9'h002, 4'd3, 4'd1, 1'b1, 4'd2);
    ta[4]  = mk(0, 1, 0, 8'h01, 9'h002, 4'd3, 4'd1, 1'b1, 4'd2);
    ta[5]  = mk(1, 1, 1, 8'h01, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0);
    ta[6]  = mk(1, 1, 0, 8'h05, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0);
    ta[7]  = mk(1, 1, 0, 8'h01, 9'h000, 4'd2, 4'd0, 1'b0, 4'd0);
    ta[8]  = mk(1, 1, 0, 8'h04, 9'h000, 4'd3, 4'd0, 1'b0, 4'd0);
    ta[9]  = mk(1, 0, 1, 8'h00, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0);
    ta[10] = mk(1, 1, 0, 8'h01, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0);
    ta[11] = mk(1, 1, 0, 8'h02, 9'h000, 4'd2, 4'd0, 1'b0, 4'd0);
    ta[12] = mk(1, 1, 1, 8'h04, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0);
    ta[13] = mk(1, 1, 0, 8'h04, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0);
    ta[14] = mk(1, 0, 1, 8'h00, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0);
    ta[15] = mk(1, 1, 0, 8'h01, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0);
    ta[16] = mk(1, 1, 0, 8'h04, 9'h002, 4'd2, 4'd1, 1'b1, 4'd1);

    // STE2: ALL start, matches 0x7F, reports; gaps hold state
    tb[0] = mk(1, 1, 0, 8'h7F, 9'h004, 4'd1, 4'd1, 1'b1, 4'd0);
    tb[1] = mk(1, 0, 0, 8'h00, 9'h004, 4'd1, 4'd1, 1'b1, 4'd0);
    tb[2] = mk(1, 1, 0, 8'h7F, 9'h004, 4'd2, 4'd2, 1'b1, 4'd0);
    tb[3] = mk(1, 0, 0, 8'h00, 9'h004, 4'd2, 4'd2, 1'b1, 4'd0);
    tb[4] = mk(1, 1, 0, 8'h7F, 9'h004, 4'd3, 4'd3, 1'b1, 4'd0);
    tb[5] = mk(1, 1, 0, 8'h00, 9'h000, 4'd4, 4'd3, 1'b1, 4'd0);

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset0");
    reset = 1'b1;

    cfg_wr(OP_ATTR, 0, 0, 1);
    for (int a = 0; a < 4; a++) cfg_wr(OP_MATCH, 0, a, 1);
    cfg_wr(OP_EDGE, 0, 0, 1);
    cfg_wr(OP_EDGE, 1, 0, 1);
    cfg_wr(OP_MATCH, 1, 4, 1);
    cfg_wr(OP_ATTR, 1, 0, 4);
    chk("cfg_ok.cfg_err", 32'(cfg_err), 32'd0);

    for (int i = 0; i < 17; i++) apply($sformatf("seqA%0d", i), ta[i]);
    idle_inputs();

    cfg_wr(OP_ATTR, 2, 0, 6);
    cfg_wr(OP_MATCH, 2, 8'h7F, 1);
    cfg_wr(OP_CLEAR, 15, 0, 0);
    chk("clear.cfg_err", 32'(cfg_err), 32'd0);
    check_outs("clear", mk(0, 0, 0, 8'h00, 9'h000, 4'd0, 4'd0, 1'b0, 4'd0));

    for (int i = 0; i < 6; i++) apply($sformatf("seqB%0d", i), tb[i]);
    idle_inputs();

    // Config write while running is rejected
    run = 1'b1;
    cfg_wr(OP_MATCH, 0, 8'h10, 1);
    chk("run_wr.cfg_err", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    chk("run_wr.cfg_err_pulse", 32'(cfg_err), 32'd0);
    run = 1'b0;
    cfg_wr(OP_CLEAR, 0, 0, 0);
    apply("run_wr.s10", mk(1, 1, 0, 8'h10, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0));
    apply("run_wr.s04", mk(1, 1, 0, 8'h04, 9'h000, 4'd2, 4'd0, 1'b0, 4'd0));
    idle_inputs();

    // Out-of-range STE index is rejected; in-range write does land
    cfg_wr(OP_MATCH, 9, 8'h10, 1);
    chk("bad_ste.cfg_err", 32'(cfg_err), 32'd1);
    cfg_wr(OP_MATCH, 0, 8'h10, 1);
    chk("good_wr.cfg_err", 32'(cfg_err), 32'd0);
    cfg_wr(OP_CLEAR, 0, 0, 0);
    apply("good_wr.s10", mk(1, 1, 0, 8'h10, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0));
    apply("good_wr.s04", mk(1, 1, 0, 8'h04, 9'h002, 4'd2, 4'd1, 1'b1, 4'd1));
    idle_inputs();

    // Saturation: STE2 reports on every 0x7F
    cfg_wr(OP_CLEAR, 0, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      logic [3:0] n;
      n = (k > 15) ? 4'd15 : 4'(k);
      apply($sformatf("sat%0d", k), mk(1, 1, 0, 8'h7F, 9'h004, n, n, 1'b1, 4'd0));
    end
    idle_inputs();

    // Reset clears outputs and configuration
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero("reset1");
    reset = 1'b1;
    apply("post_rst", mk(1, 1, 0, 8'h7F, 9'h000, 4'd1, 4'd0, 1'b0, 4'd0));
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
